// File: rtl/cpu_harness.sv
// Run harness for the pipelined CPU: loadable IMEM/DMEM, reset/start sequencing,
// HALT detection with pipeline drain, and done/timeout reporting with a cycle count.
module cpu_harness #(
    parameter int             DW         = 16,
    parameter int             IAW        = 8,
    parameter int             DAW        = 8,
    parameter int             OPW        = 5,
    parameter logic [OPW-1:0] HALT_OP    = 5'b00001,
    parameter int             RST_CYCLES = 2,
    parameter int             DRAIN      = 4,
    parameter int             MAX_CYCLES = 1000,
    parameter int             CW         = 16
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   ld_en,
    input  logic                                   ld_sel,
    input  logic [((IAW > DAW) ? IAW : DAW)-1:0]   ld_addr,
    input  logic [DW-1:0]                          ld_data,
    input  logic                                   run,
    input  logic [DAW-1:0]                         rd_addr,
    output logic [DW-1:0]                          rd_data,
    output logic                                   cpu_enable,
    output logic                                   cpu_reset,
    output logic                                   cpu_start,
    input  logic [IAW-1:0]                         i_addr,
    output logic [DW-1:0]                          i_datain,
    input  logic [DAW-1:0]                         d_addr,
    input  logic [DW-1:0]                          d_dataout,
    input  logic                                   d_we,
    output logic [DW-1:0]                          d_datain,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   timeout,
    output logic [CW-1:0]                          cycles
);

    typedef enum logic [2:0] {IDLE, RST, START, RUN, DRAIN_S, DONE, TIMEOUT} state_t;

    state_t        state;
    logic [15:0]   cnt;
    logic [DW-1:0] imem [2**IAW];
    logic [DW-1:0] dmem [2**DAW];
    logic          halt_seen;
    logic          host_ok;
    logic          cpu_wr_ok;
    logic [CW-1:0] cycles_next;

    assign i_datain    = imem[i_addr];
    assign d_datain    = dmem[d_addr];
    assign halt_seen   = (i_datain[DW-1 -: OPW] == HALT_OP);
    assign host_ok     = state inside {IDLE, DONE, TIMEOUT};
    assign cpu_wr_ok   = state inside {RUN, DRAIN_S};
    assign cycles_next = (cycles == '1) ? cycles : cycles + CW'(1);

    // Memories have no reset so programs survive an aborted run; host and CPU never write in the same state.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (host_ok && ld_en) begin
                if (ld_sel)
                    dmem[ld_addr[DAW-1:0]] <= ld_data;
                else
                    imem[ld_addr[IAW-1:0]] <= ld_data;
            end else if (cpu_wr_ok && d_we) begin
                dmem[d_addr] <= d_dataout;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            rd_data <= '0;
        else
            rd_data <= dmem[rd_addr];
    end

    // Outputs are loaded with the value of the state being entered, so they track state exactly.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cycles     <= '0;
            cpu_enable <= 1'b0;
            cpu_reset  <= 1'b0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, TIMEOUT: begin
                    if (run) begin
                        state      <= RST;
                        cnt        <= 16'(RST_CYCLES - 1);
                        cycles     <= '0;
                        cpu_reset  <= 1'b0;
                        cpu_enable <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                RST: begin
                    if (cnt == '0) begin
                        state      <= START;
                        cpu_reset  <= 1'b1;
                        cpu_start  <= 1'b1;
                        cpu_enable <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                START: begin
                    state     <= RUN;
                    cpu_start <= 1'b0;
                end
                RUN: begin
                    cycles <= cycles_next;
                    // HALT takes priority over a timeout landing on the same cycle.
                    if (halt_seen) begin
                        if (DRAIN == 0) begin
                            state      <= DONE;
                            cpu_enable <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state <= DRAIN_S;
                            cnt   <= 16'(DRAIN - 1);
                        end
                    end else if (cycles_next >= CW'(MAX_CYCLES)) begin
                        state      <= TIMEOUT;
                        cpu_enable <= 1'b0;
                        busy       <= 1'b0;
                        timeout    <= 1'b1;
                    end
                end
                DRAIN_S: begin
                    cycles <= cycles_next;
                    if (cnt == '0) begin
                        state      <= DONE;
                        cpu_enable <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_harness.sv
// Bench for cpu_harness: a tiny single-cycle CPU stub executes LOAD/ADD/STORE/HALT,
// and a queue-based scoreboard checks status probes, readbacks and run completions.
module tb_cpu_harness;

    localparam logic [47:0] M_FLAGS = 48'h0000_0000_003F;
    localparam logic [47:0] M_CYC   = 48'h0000_FFFF_0000;
    localparam logic [47:0] M_RD    = 48'hFFFF_0000_0000;
    localparam logic [47:0] M_ALL   = 48'hFFFF_FFFF_FFFF;

    // Flag order: busy, done, timeout, cpu_reset, cpu_start, cpu_enable
    localparam logic [5:0] S_IDLE  = 6'b000000;
    localparam logic [5:0] S_RST   = 6'b100000;
    localparam logic [5:0] S_START = 6'b100111;
    localparam logic [5:0] S_RUN   = 6'b100101;
    localparam logic [5:0] S_DONE  = 6'b010100;
    localparam logic [5:0] S_TOUT  = 6'b001100;

    localparam logic [15:0] I_NOP  = 16'h0000;
    localparam logic [15:0] I_HALT = 16'h0800;
    localparam logic [15:0] I_LD1  = 16'h1100;
    localparam logic [15:0] I_LD2  = 16'h1201;
    localparam logic [15:0] I_ADD  = 16'h2328;
    localparam logic [15:0] I_ST3  = 16'h1B02;

    typedef struct {
        string       name;
        logic [47:0] exp;
        logic [47:0] mask;
    } chk_t;

    chk_t status_q[$];
    chk_t end_q[$];
    chk_t rd_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        clock;
    logic        reset;
    logic        ld_en;
    logic        ld_sel;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        run;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        cpu_enable;
    logic        cpu_reset;
    logic        cpu_start;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;

    logic        probe;
    logic        rd_req;
    logic        rd_pend;
    logic        prev_end = 1'b0;
    logic        frc_we;
    logic [7:0]  frc_addr;
    logic [15:0] frc_data;

    logic [7:0]  pc;
    logic [15:0] regs [8];
    logic        exec;
    logic [4:0]  op;

    cpu_harness #(
        .MAX_CYCLES(20)
    ) dut (
        .clock(clock), .reset(reset),
        .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .run(run), .rd_addr(rd_addr), .rd_data(rd_data),
        .cpu_enable(cpu_enable), .cpu_reset(cpu_reset), .cpu_start(cpu_start),
        .i_addr(i_addr), .i_datain(i_datain),
        .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
        .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CPU stub: executes one instruction per enabled cycle, holds while start is pulsed.
    assign exec   = cpu_enable && !cpu_start && cpu_reset;
    assign op     = i_datain[15:11];
    assign i_addr = pc;

    always_comb begin
        d_we      = frc_we || (exec && op == 5'd3);
        d_addr    = frc_we ? frc_addr : i_datain[7:0];
        d_dataout = frc_we ? frc_data : regs[i_datain[10:8]];
    end

    always @(posedge clock) begin
        if (!cpu_reset) begin
            pc <= '0;
        end else if (exec) begin
            pc <= pc + 8'd1;
            if (op == 5'd2)
                regs[i_datain[10:8]] <= d_datain;
            else if (op == 5'd4)
                regs[i_datain[10:8]] <= regs[i_datain[7:5]] + regs[i_datain[4:2]];
        end
    end

    always @(posedge clock) rd_pend <= rd_req;

    function automatic logic [47:0] st(input logic [5:0] f, input logic [15:0] cyc, input logic [15:0] rd);
        return {rd, cyc, 10'b0, f};
    endfunction

    function automatic logic [47:0] endv(input logic d, input logic t, input logic en, input logic [15:0] cyc);
        return {29'b0, d, t, en, cyc};
    endfunction

    function automatic chk_t mk(input string name, input logic [47:0] exp, input logic [47:0] mask);
        chk_t c;
        c.name = name;
        c.exp  = exp;
        c.mask = mask;
        return c;
    endfunction

    task automatic checkOutput(input chk_t c, input logic [47:0] obs);
        n_checks++;
        if ((obs & c.mask) !== (c.exp & c.mask)) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", c.name, obs & c.mask, c.exp & c.mask);
        end
    endtask

    task automatic noteUnexpected(input string what);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: DUT presented output with no expectation queued", what);
    endtask

    // Monitor: pops the matching queue whenever the DUT presents a probed, readback or completion output.
    initial begin
        forever begin
            @(negedge clock);
            if (probe) begin
                if (status_q.size() == 0) noteUnexpected("status");
                else checkOutput(status_q.pop_front(),
                                 {rd_data, cycles, 10'b0, busy, done, timeout, cpu_reset, cpu_start, cpu_enable});
            end
            if (rd_pend) begin
                if (rd_q.size() == 0) noteUnexpected("readback");
                else checkOutput(rd_q.pop_front(), {32'b0, rd_data});
            end
            if ((done || timeout) && !prev_end) begin
                if (end_q.size() == 0) noteUnexpected("completion");
                else checkOutput(end_q.pop_front(), endv(done, timeout, cpu_enable, cycles));
            end
            prev_end = done || timeout;
        end
    end

    task automatic probeStatus(input string name, input logic [47:0] exp, input logic [47:0] mask);
        status_q.push_back(mk(name, exp, mask));
        probe = 1'b1;
        @(negedge clock);
        #1 probe = 1'b0;
    endtask

    task automatic applyStimulus(input logic sel, input logic [7:0] addr, input logic [15:0] data);
        @(posedge clock);
        #1;
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = addr;
        ld_data = data;
        @(posedge clock);
        #1 ld_en = 1'b0;
    endtask

    task automatic readBack(input string name, input logic [7:0] addr, input logic [15:0] exp);
        @(posedge clock);
        #1;
        rd_addr = addr;
        rd_req  = 1'b1;
        rd_q.push_back(mk(name, {32'b0, exp}, 48'h0000_0000_FFFF));
        @(posedge clock);
        #1 rd_req = 1'b0;
    endtask

    task automatic startRun(input string name, input bit expect_end, input logic [47:0] exp_end);
        @(posedge clock);
        #1 run = 1'b1;
        if (expect_end) end_q.push_back(mk({name, "_end"}, exp_end, M_ALL));
        @(posedge clock);
        #1 run = 1'b0;
        probeStatus({name, "_rst_a"}, st(S_RST, 16'd0, 16'd0), M_FLAGS | M_CYC);
        @(posedge clock);
        #1 probeStatus({name, "_rst_b"}, st(S_RST, 16'd0, 16'd0), M_FLAGS | M_CYC);
        @(posedge clock);
        #1 probeStatus({name, "_start"}, st(S_START, 16'd0, 16'd0), M_FLAGS | M_CYC);
        @(posedge clock);
        #1 probeStatus({name, "_run1"}, st(S_RUN, 16'd0, 16'd0), M_FLAGS | M_CYC);
    endtask

    task automatic waitEnd(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (done || timeout) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: got no completion within %0d cycles, expected done or timeout", name, limit);
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        rd_addr = '0; rd_req = 1'b0; probe = 1'b0; frc_we = 1'b0; frc_addr = '0; frc_data = '0;

        repeat (3) @(posedge clock);
        #1 probeStatus("reset_state", st(S_IDLE, 16'd0, 16'd0), M_ALL);
        @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < 256; i++) applyStimulus(1'b0, 8'(i), I_NOP);
        applyStimulus(1'b1, 8'd0, 16'h00AB);
        applyStimulus(1'b1, 8'd1, 16'h0003);
        applyStimulus(1'b1, 8'd2, 16'h0000);
        applyStimulus(1'b1, 8'd5, 16'h1234);
        applyStimulus(1'b0, 8'd0, I_LD1);
        applyStimulus(1'b0, 8'd1, I_LD2);
        applyStimulus(1'b0, 8'd2, I_ADD);
        applyStimulus(1'b0, 8'd3, I_ST3);
        applyStimulus(1'b0, 8'd4, I_HALT);
        readBack("host_load_dmem0", 8'd0, 16'h00AB);

        // Program: HALT fetched in RUN cycle 5, so cycles = 5 + 4.
        startRun("prog", 1'b1, endv(1'b1, 1'b0, 1'b0, 16'd9));
        waitEnd("prog", 100);
        @(posedge clock);
        #1 probeStatus("prog_done_state", st(S_DONE, 16'd9, 16'd0), M_FLAGS | M_CYC);
        readBack("prog_sum", 8'd2, 16'h00AE);
        @(posedge clock);
        #1;
        frc_we = 1'b1; frc_addr = 8'd2; frc_data = 16'h5555;
        @(posedge clock);
        #1 frc_we = 1'b0;
        readBack("store_in_done_ignored", 8'd2, 16'h00AE);

        // HALT in RUN cycle 20 coincides with MAX_CYCLES; drain wins.
        applyStimulus(1'b0, 8'd4, I_NOP);
        applyStimulus(1'b0, 8'd19, I_HALT);
        startRun("halt_max", 1'b1, endv(1'b1, 1'b0, 1'b0, 16'd24));
        waitEnd("halt_max", 100);
        @(posedge clock);
        #1 probeStatus("halt_max_state", st(S_DONE, 16'd24, 16'd0), M_FLAGS | M_CYC);

        applyStimulus(1'b0, 8'd19, I_NOP);
        startRun("tout", 1'b1, endv(1'b0, 1'b1, 1'b0, 16'd20));
        applyStimulus(1'b1, 8'd5, 16'hFFFF);
        waitEnd("tout", 100);
        @(posedge clock);
        #1 probeStatus("tout_state", st(S_TOUT, 16'd20, 16'd0), M_FLAGS | M_CYC);
        readBack("load_in_run_ignored", 8'd5, 16'h1234);

        applyStimulus(1'b0, 8'd4, I_HALT);
        applyStimulus(1'b1, 8'd2, 16'h0000);
        startRun("abort", 1'b0, '0);
        @(posedge clock);
        #1;
        rd_addr = 8'd0;
        reset   = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        probeStatus("mid_run_reset", st(S_IDLE, 16'd0, 16'd0), M_ALL);
        readBack("retained_dmem0", 8'd0, 16'h00AB);
        readBack("retained_dmem1", 8'd1, 16'h0003);
        readBack("retained_dmem2", 8'd2, 16'h0000);

        startRun("rerun", 1'b1, endv(1'b1, 1'b0, 1'b0, 16'd9));
        waitEnd("rerun", 100);
        readBack("rerun_sum", 8'd2, 16'h00AE);

        repeat (4) @(posedge clock);
        if (status_q.size() + rd_q.size() + end_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL pending: got %0d unconsumed expectations, expected 0",
                     status_q.size() + rd_q.size() + end_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
